// File: rtl/stack_data_memory.sv
// ----------------------------------------------------------------------------
// stack_data_memory
//
// Data memory for the MEM stage with a hardware full-descending stack.
// One random read port (registered, 1-cycle latency), one random write port,
// plus push/pop. A push takes its word from wr_data or the CCR flags, or it
// pushes a two-word return address (pc_in). A pop returns one word or two words.
// The stack pointer points at the last pushed word: sp == DEPTH means empty and
// sp == 0 means full. Two-word operations take two cycles (busy high for the
// second cycle). Overflow and underflow are sticky until err_clr.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   rd_en/rd_addr        random read request -> rd_data/rd_valid next cycle
//   wr_en/wr_addr/wr_data random write (a stack write to the same address wins)
//   push/push_sel        push request; source 0 wr_data, 1 pc_in (2 words),
//                        2 flags_in, 3 same as 0
//   pc_in, flags_in      wide-push return address, CCR flags
//   pop/pop_wide         pop request; one word (zero-extended) or two words
//   err_clr              clears the sticky overflow/underflow flags
//   pop_data/pop_valid   popped value (held until the next pop) and 1-cycle strobe
//   busy                 second half of a two-word op in progress
//   sp                   stack pointer (ADDR_W+1 bits)
//   overflow/underflow   sticky error flags
// ----------------------------------------------------------------------------
module stack_data_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                push,
    input  logic [1:0]          push_sel,
    input  logic [2*DATA_W-1:0] pc_in,
    input  logic [2:0]          flags_in,
    input  logic                pop,
    input  logic                pop_wide,
    input  logic                err_clr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic [2*DATA_W-1:0] pop_data,
    output logic                pop_valid,
    output logic                busy,
    output logic [ADDR_W:0]     sp,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PUSH_LO = 2'd1;
    localparam logic [1:0] ST_POP_HI  = 2'd2;

    localparam logic [ADDR_W:0] SP_EMPTY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] SP_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W:0]   sp_next;
    logic [ADDR_W:0]   sp_dec;
    logic [ADDR_W:0]   sp_inc;
    logic [DATA_W-1:0] top_word;
    logic [DATA_W-1:0] push_word;
    logic [DATA_W-1:0] pop_lo;
    logic [DATA_W-1:0] pc_lo;
    logic              push_wide;
    logic              stack_empty;
    logic              one_word;
    logic              stack_we;
    logic [ADDR_W-1:0] stack_waddr;
    logic [DATA_W-1:0] stack_wdata;
    logic              set_ovf;
    logic              set_unf;
    logic              pop_single;
    logic              pop_lo_cap;
    logic              pop_hi_cap;
    logic              pc_lo_cap;

    assign sp_dec    = sp - SP_ONE;
    assign sp_inc    = sp + SP_ONE;
    assign top_word  = mem[sp[ADDR_W-1:0]];
    assign push_wide = (push_sel == 2'd1);
    assign push_word = (push_sel == 2'd2) ? {{(DATA_W-3){1'b0}}, flags_in} : wr_data;
    // sp never exceeds DEPTH, so its top bit alone marks the empty stack
    assign stack_empty = sp[ADDR_W];
    assign one_word    = !sp[ADDR_W] && (sp[ADDR_W-1:0] == {ADDR_W{1'b1}});
    assign busy        = (state != ST_IDLE);

    // Stack control: decides the stack write, next sp/state and error events.
    // A combined push+pop is a swap only when both are single-word; any wide
    // combination executes the pop and silently drops the push.
    always_comb begin
        state_next  = state;
        sp_next     = sp;
        stack_we    = 1'b0;
        stack_waddr = '0;
        stack_wdata = '0;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        pop_single  = 1'b0;
        pop_lo_cap  = 1'b0;
        pop_hi_cap  = 1'b0;
        pc_lo_cap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop && push && !pop_wide && !push_wide) begin
                    if (!stack_empty) begin
                        pop_single  = 1'b1;
                        stack_we    = 1'b1;
                        stack_waddr = sp[ADDR_W-1:0];
                        stack_wdata = push_word;
                    end else begin
                        set_unf = 1'b1;
                    end
                end else if (pop) begin
                    if (!pop_wide) begin
                        if (!stack_empty) begin
                            pop_single = 1'b1;
                            sp_next    = sp_inc;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end else if (stack_empty || one_word) begin
                        set_unf = 1'b1;
                    end else begin
                        pop_lo_cap = 1'b1;
                        sp_next    = sp_inc;
                        state_next = ST_POP_HI;
                    end
                end else if (push) begin
                    if (!push_wide) begin
                        if (sp != '0) begin
                            stack_we    = 1'b1;
                            stack_waddr = sp_dec[ADDR_W-1:0];
                            stack_wdata = push_word;
                            sp_next     = sp_dec;
                        end else begin
                            set_ovf = 1'b1;
                        end
                    end else if (sp[ADDR_W:1] == '0) begin
                        set_ovf = 1'b1;
                    end else begin
                        stack_we    = 1'b1;
                        stack_waddr = sp_dec[ADDR_W-1:0];
                        stack_wdata = pc_in[2*DATA_W-1:DATA_W];
                        sp_next     = sp_dec;
                        pc_lo_cap   = 1'b1;
                        state_next  = ST_PUSH_LO;
                    end
                end
            end
            ST_PUSH_LO: begin
                stack_we    = 1'b1;
                stack_waddr = sp_dec[ADDR_W-1:0];
                stack_wdata = pc_lo;
                sp_next     = sp_dec;
                state_next  = ST_IDLE;
            end
            ST_POP_HI: begin
                pop_hi_cap = 1'b1;
                sp_next    = sp_inc;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Stack registers, pop result and sticky flags; a new error beats err_clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sp        <= SP_EMPTY;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            pop_lo    <= '0;
            pc_lo     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_next;
            sp        <= sp_next;
            pop_valid <= pop_single | pop_hi_cap;
            if (pop_single) begin
                pop_data <= {{DATA_W{1'b0}}, top_word};
            end
            if (pop_hi_cap) begin
                pop_data <= {top_word, pop_lo};
            end
            if (pop_lo_cap) begin
                pop_lo <= top_word;
            end
            if (pc_lo_cap) begin
                pc_lo <= pc_in[DATA_W-1:0];
            end
            overflow  <= set_ovf | (overflow & ~err_clr);
            underflow <= set_unf | (underflow & ~err_clr);
        end
    end

    // Memory array (not reset); the stack write is issued last so it wins
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (stack_we) begin
            mem[stack_waddr] <= stack_wdata;
        end
    end

    // Registered read port; reads the pre-edge contents (read-before-write)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_stack_data_memory.sv
// ----------------------------------------------------------------------------
// tb_stack_data_memory
//
// Directed, table-driven bench for stack_data_memory (DATA_W=16, ADDR_W=10).
// Each table row drives one cycle of inputs and lists the outputs expected
// just after the following rising edge. Hand-written sequences cover the full
// stack/overflow case and reset in the middle of a wide push.
// ----------------------------------------------------------------------------
module tb_stack_data_memory;

    typedef struct {
        logic        rd_en;
        logic [9:0]  rd_addr;
        logic        wr_en;
        logic [9:0]  wr_addr;
        logic [15:0] wr_data;
        logic        push;
        logic [1:0]  push_sel;
        logic [31:0] pc_in;
        logic [2:0]  flags_in;
        logic        pop;
        logic        pop_wide;
        logic        err_clr;
        logic [10:0] exp_sp;
        logic        exp_busy;
        logic        exp_pop_valid;
        logic [31:0] exp_pop_data;
        logic        exp_rd_valid;
        logic [15:0] exp_rd_data;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        push;
    logic [1:0]  push_sel;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic        pop;
    logic        pop_wide;
    logic        err_clr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [31:0] pop_data;
    logic        pop_valid;
    logic        busy;
    logic [10:0] sp;
    logic        overflow;
    logic        underflow;

    int   n_vec;
    int   n_bad;
    vec_t vecs[$];
    vec_t t;

    stack_data_memory #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .push     (push),
        .push_sel (push_sel),
        .pc_in    (pc_in),
        .flags_in (flags_in),
        .pop      (pop),
        .pop_wide (pop_wide),
        .err_clr  (err_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .pop_data (pop_data),
        .pop_valid(pop_valid),
        .busy     (busy),
        .sp       (sp),
        .overflow (overflow),
        .underflow(underflow)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle row: no requests, expected sp and held pop_data given, no strobes
    function automatic vec_t base(input logic [10:0] e_sp, input logic [31:0] e_pd);
        vec_t r;
        r.rd_en = 1'b0;  r.rd_addr = '0;  r.wr_en = 1'b0;  r.wr_addr = '0;
        r.wr_data = '0;  r.push = 1'b0;   r.push_sel = '0; r.pc_in = '0;
        r.flags_in = '0; r.pop = 1'b0;    r.pop_wide = 1'b0; r.err_clr = 1'b0;
        r.exp_sp = e_sp; r.exp_busy = 1'b0; r.exp_pop_valid = 1'b0;
        r.exp_pop_data = e_pd; r.exp_rd_valid = 1'b0; r.exp_rd_data = '0;
        r.exp_ovf = 1'b0; r.exp_unf = 1'b0;
        return r;
    endfunction

    // One comparison; any mismatch prints a FAIL line
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        push = 1'b0; push_sel = '0; pc_in = '0; flags_in = '0;
        pop = 1'b0; pop_wide = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive a row on the falling edge, sample 1 unit after the rising edge
    task automatic apply_stimulus(input vec_t v, input int idx);
        @(negedge clk);
        rd_en = v.rd_en; rd_addr = v.rd_addr; wr_en = v.wr_en; wr_addr = v.wr_addr;
        wr_data = v.wr_data; push = v.push; push_sel = v.push_sel; pc_in = v.pc_in;
        flags_in = v.flags_in; pop = v.pop; pop_wide = v.pop_wide; err_clr = v.err_clr;
        @(posedge clk);
        #1;
        check_output($sformatf("v%0d sp", idx), 32'(sp), 32'(v.exp_sp));
        check_output($sformatf("v%0d busy", idx), 32'(busy), 32'(v.exp_busy));
        check_output($sformatf("v%0d pop_valid", idx), 32'(pop_valid), 32'(v.exp_pop_valid));
        check_output($sformatf("v%0d pop_data", idx), pop_data, v.exp_pop_data);
        check_output($sformatf("v%0d rd_valid", idx), 32'(rd_valid), 32'(v.exp_rd_valid));
        if (v.exp_rd_valid) begin
            check_output($sformatf("v%0d rd_data", idx), 32'(rd_data), 32'(v.exp_rd_data));
        end
        check_output($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf));
        check_output($sformatf("v%0d underflow", idx), 32'(underflow), 32'(v.exp_unf));
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        idle_inputs();

        // Vector table: pushes/pops, wide ops, errors, swap, port interplay
        t = base(11'd1023, 32'h0); t.push = 1'b1; t.wr_data = 16'h1234; vecs.push_back(t);
        t = base(11'd1022, 32'h0); t.push = 1'b1; t.wr_data = 16'hABCD; vecs.push_back(t);
        t = base(11'd1023, 32'h0000ABCD); t.pop = 1'b1; t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00001234); t.pop = 1'b1; t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00001234); vecs.push_back(t);
        t = base(11'd1023, 32'h00001234); t.push = 1'b1; t.push_sel = 2'd1; t.pc_in = 32'h0001_0200;
        t.exp_busy = 1'b1; vecs.push_back(t);
        t = base(11'd1022, 32'h00001234); vecs.push_back(t);
        t = base(11'd1022, 32'h00001234); t.rd_en = 1'b1; t.rd_addr = 10'd1023;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h0001; vecs.push_back(t);
        t = base(11'd1022, 32'h00001234); t.rd_en = 1'b1; t.rd_addr = 10'd1022;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h0200; vecs.push_back(t);
        t = base(11'd1023, 32'h00001234); t.pop = 1'b1; t.pop_wide = 1'b1; t.exp_busy = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00010200); t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00010200); vecs.push_back(t);
        t = base(11'd1024, 32'h00010200); t.pop = 1'b1; t.exp_unf = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00010200); t.err_clr = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00010200); t.pop = 1'b1; t.err_clr = 1'b1; t.exp_unf = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00010200); t.err_clr = 1'b1; vecs.push_back(t);
        t = base(11'd1023, 32'h00010200); t.push = 1'b1; t.push_sel = 2'd2; t.flags_in = 3'b101;
        t.wr_en = 1'b1; t.wr_addr = 10'd7; t.wr_data = 16'h5555; vecs.push_back(t);
        t = base(11'd1023, 32'h00010200); t.rd_en = 1'b1; t.rd_addr = 10'd7;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h5555; vecs.push_back(t);
        t = base(11'd1023, 32'h00010200); t.rd_en = 1'b1; t.rd_addr = 10'd1023;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h0005; vecs.push_back(t);
        t = base(11'd1022, 32'h00010200); t.push = 1'b1; t.wr_data = 16'h0042; vecs.push_back(t);
        t = base(11'd1022, 32'h00000042); t.push = 1'b1; t.wr_data = 16'h0077; t.pop = 1'b1;
        t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1022, 32'h00000042); t.rd_en = 1'b1; t.rd_addr = 10'd1022;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h0077; vecs.push_back(t);
        t = base(11'd1022, 32'h00000042); t.wr_en = 1'b1; t.wr_addr = 10'd5; t.wr_data = 16'hAAAA; vecs.push_back(t);
        t = base(11'd1022, 32'h00000042); t.wr_en = 1'b1; t.wr_addr = 10'd5; t.wr_data = 16'hBBBB;
        t.rd_en = 1'b1; t.rd_addr = 10'd5; t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'hAAAA; vecs.push_back(t);
        t = base(11'd1022, 32'h00000042); t.rd_en = 1'b1; t.rd_addr = 10'd5;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'hBBBB; vecs.push_back(t);
        t = base(11'd1021, 32'h00000042); t.push = 1'b1; t.push_sel = 2'd2; t.flags_in = 3'b011;
        t.wr_en = 1'b1; t.wr_addr = 10'd1021; t.wr_data = 16'hDEAD; vecs.push_back(t);
        t = base(11'd1021, 32'h00000042); t.rd_en = 1'b1; t.rd_addr = 10'd1021;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h0003; vecs.push_back(t);
        t = base(11'd1022, 32'h00000003); t.pop = 1'b1; t.push = 1'b1; t.push_sel = 2'd1;
        t.pc_in = 32'hCAFE_F00D; t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1023, 32'h00000003); t.pop = 1'b1; t.pop_wide = 1'b1; t.push = 1'b1;
        t.wr_data = 16'h3333; t.exp_busy = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00050077); t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1023, 32'h00050077); t.push = 1'b1; t.wr_data = 16'h0001; vecs.push_back(t);
        t = base(11'd1023, 32'h00050077); t.pop = 1'b1; t.pop_wide = 1'b1; t.exp_unf = 1'b1; vecs.push_back(t);
        t = base(11'd1023, 32'h00050077); t.err_clr = 1'b1; vecs.push_back(t);
        t = base(11'd1024, 32'h00000001); t.pop = 1'b1; t.exp_pop_valid = 1'b1; vecs.push_back(t);
        t = base(11'd1023, 32'h00000001); t.push = 1'b1; t.push_sel = 2'd1; t.pc_in = 32'h1234_5678;
        t.exp_busy = 1'b1; vecs.push_back(t);
        t = base(11'd1022, 32'h00000001); t.push = 1'b1; t.wr_data = 16'h7777; t.pop = 1'b1; vecs.push_back(t);
        t = base(11'd1022, 32'h00000001); t.rd_en = 1'b1; t.rd_addr = 10'd1022;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h5678; vecs.push_back(t);
        t = base(11'd1022, 32'h00000001); t.rd_en = 1'b1; t.rd_addr = 10'd1023;
        t.exp_rd_valid = 1'b1; t.exp_rd_data = 16'h1234; vecs.push_back(t);

        // Reset state
        do_reset();
        #1;
        check_output("reset sp", 32'(sp), 32'd1024);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset pop_valid", 32'(pop_valid), 32'd0);
        check_output("reset pop_data", pop_data, 32'd0);
        check_output("reset rd_valid", 32'(rd_valid), 32'd0);
        check_output("reset rd_data", 32'(rd_data), 32'd0);
        check_output("reset overflow", 32'(overflow), 32'd0);
        check_output("reset underflow", 32'(underflow), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Fill the whole stack, then overflow on single and wide pushes
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            idle_inputs();
            push = 1'b1;
            wr_data = 16'(i);
        end
        drive_cycle();
        check_output("fill sp", 32'(sp), 32'd0);
        check_output("fill overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        idle_inputs();
        push = 1'b1;
        wr_data = 16'hFFFF;
        drive_cycle();
        check_output("full push overflow", 32'(overflow), 32'd1);
        check_output("full push sp", 32'(sp), 32'd0);
        @(negedge clk);
        idle_inputs();
        rd_en = 1'b1;
        rd_addr = 10'd0;
        drive_cycle();
        check_output("full mem0", 32'(rd_data), 32'h03FF);
        @(negedge clk);
        idle_inputs();
        pop = 1'b1;
        err_clr = 1'b1;
        drive_cycle();
        check_output("full pop data", pop_data, 32'h000003FF);
        check_output("full pop sp", 32'(sp), 32'd1);
        check_output("full clr overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        idle_inputs();
        push = 1'b1;
        push_sel = 2'd1;
        pc_in = 32'hAAAA_BBBB;
        drive_cycle();
        check_output("wide at sp1 overflow", 32'(overflow), 32'd1);
        check_output("wide at sp1 sp", 32'(sp), 32'd1);
        check_output("wide at sp1 busy", 32'(busy), 32'd0);

        // Reset asserted during PUSH_LO abandons the half-done push
        do_reset();
        @(negedge clk);
        idle_inputs();
        push = 1'b1;
        push_sel = 2'd1;
        pc_in = 32'h0BAD_F00D;
        drive_cycle();
        check_output("midop busy", 32'(busy), 32'd1);
        check_output("midop sp", 32'(sp), 32'd1023);
        #1;
        rst = 1'b0;
        #1;
        check_output("midop reset sp", 32'(sp), 32'd1024);
        check_output("midop reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        drive_cycle();
        check_output("after reset sp", 32'(sp), 32'd1024);
        check_output("after reset busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_data_memory.md
# stack_data_memory

Parametrised data memory with a hardware descending stack, replacing the fixed 16-bit single-word stack memory. Sits in the MEM stage of the pipelined processor. Provides one random-access read port and one write port, plus push/pop with selectable push source. Supports two-word (wide) push/pop for return addresses, stack overflow/underflow detection, and a registered read path on the rising edge.

## Interface
- DATA_W, 16, word width
- ADDR_W, 10, address width; DEPTH = 2^ADDR_W words
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  random read request
- rd_addr  in  ADDR_W  read address
- wr_en  in  1  random write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data; also the push source when push_sel=0
- push  in  1  push request
- push_sel  in  2  push source: 0 wr_data (1 word); 1 pc_in (2 words); 2 {zeros, flags_in} (1 word); 3 reserved, treated as 0
- pc_in  in  2*DATA_W  return address for wide push
- flags_in  in  3  CCR flags for flag push
- pop  in  1  pop request
- pop_wide  in  1  1: pop 2 words into pop_data; 0: pop 1 word into pop_data[DATA_W-1:0], upper half 0
- err_clr  in  1  clears the sticky error flags
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data valid this cycle
- pop_data  out  2*DATA_W  popped value
- pop_valid  out  1  pop_data valid this cycle
- busy  out  1  stack FSM mid two-word op; new push/pop ignored
- sp  out  ADDR_W+1  stack pointer
- overflow  out  1  sticky: push rejected for lack of space
- underflow  out  1  sticky: pop rejected for lack of data

## Operation
- Stack is full-descending: sp points at the last pushed word. Empty when sp = DEPTH. Full when sp = 0. sp is ADDR_W+1 bits wide.
- The memory array is not reset.
- On reset:
  - sp = DEPTH, FSM = IDLE
  - rd_data, pop_data = 0
  - rd_valid, pop_valid, busy, overflow, underflow = 0
- FSM states: IDLE, PUSH_LO, POP_HI.
- Single-word push, in IDLE:
  - If sp ≥ 1: write mem[sp-1] ← source, sp ← sp-1.
  - Otherwise: no write, sp unchanged, overflow ← 1.
- Wide push (push_sel=1), in IDLE:
  - If sp < 2: nothing written, sp unchanged, overflow ← 1.
  - Otherwise: write mem[sp-1] ← pc_in high half, sp ← sp-1, go to PUSH_LO with busy=1.
  - Next cycle: write mem[sp-1] ← pc_in low half (value latched at acceptance), sp ← sp-1, return to IDLE.
- Single-word pop, in IDLE:
  - If sp ≤ DEPTH-1: pop_data ← {0, mem[sp]}, sp ← sp+1, pop_valid next cycle.
  - Otherwise: underflow ← 1, no pop_valid.
- Wide pop, in IDLE:
  - If sp > DEPTH-2: underflow ← 1, nothing changes.
  - Otherwise: capture mem[sp] as the low half, sp ← sp+1, go to POP_HI with busy=1.
  - Next cycle: capture mem[sp] as the high half, sp ← sp+1, pop_valid=1 the following cycle, return to IDLE.
- push and pop in the same IDLE cycle:
  - Both single-word (pop_wide=0, push_sel≠1): swap top. pop_data ← old mem[sp], mem[sp] ← source, sp unchanged. Requires sp ≤ DEPTH-1; otherwise underflow ← 1 and nothing happens.
  - Any wide combination: pop is executed and push is dropped, with no flag.
- In PUSH_LO/POP_HI, push and pop are ignored. rd_en/wr_en are still served.
- wr_en is independent of stack ops. If wr_en and a stack write hit the same address in one cycle, the stack write wins.
- err_clr clears overflow and underflow. A same-cycle new error overrides the clear (flag stays 1).

## Timing
- Read: rd_en at edge N gives rd_data/rd_valid after edge N+1 (1-cycle latency). rd_valid is a 1-cycle pulse.
- Read-before-write: rd_addr = wr_addr in the same cycle returns the old data. Written data is readable from the next cycle.
- pop_valid is a 1-cycle pulse: 1 cycle after acceptance for single-word pop, 2 cycles for wide pop.
- pop_data holds its value until the next pop.
- busy is high exactly 1 cycle per accepted wide op.
- sp updates at every edge where a stack word is moved.
- rst low mid-op (e.g. in PUSH_LO) returns the FSM to IDLE at once with sp = DEPTH. The half-completed push is abandoned.

## Test plan
- Reset, then push wr_data=0x1234, 0xABCD, pop twice -> pop_data = 0xABCD then 0x1234; sp goes 1024→1022→1024; no error flags.
- Wide push pc_in=0x0001_0200, then wide pop -> busy high 1 cycle each; mem[1023]=0x0001, mem[1022]=0x0200; pop_data=0x00010200 two cycles after the pop request.
- Pop on empty stack -> underflow=1, pop_valid stays 0, sp=1024. Then err_clr -> underflow=0.
- Fill with 1024 single-word pushes, then one more push -> overflow=1, sp=0, mem[0] unchanged. A wide push at sp=1 -> overflow=1, sp=1.
- Push flags_in=3'b101 with push_sel=2 while wr_en writes 0x5555 to address 7 -> top-of-stack = 0x0005 and mem[7]=0x5555. Then rd_en addr 7 -> rd_data=0x5555 next cycle.
- Simultaneous single push 0x0077 and pop with top=0x0042 -> pop_data=0x0042, new top=0x0077, sp unchanged. Assert rst low during PUSH_LO -> sp=1024, busy=0 immediately.
